// File: rtl/painterengine_gpu_dma_reader.sv
// AXI4 read master: streams a linear run of 32-bit words from memory to the display FIFO.
// Issues one INCR burst at a time and never lets a burst cross a 4 KB page.
module painterengine_gpu_dma_reader #(
  parameter int PARAM_MAX_BURST = 64
) (
  input  logic        i_wire_clock,
  input  logic        i_wire_resetn,
  input  logic [31:0] i_wire_address,
  input  logic [31:0] i_wire_length,
  output logic        o_wire_done,
  output logic        o_wire_error,
  output logic [31:0] o_wire_data,
  output logic        o_wire_data_valid,
  input  logic        i_wire_data_next,
  output logic [31:0] o_wire_axi_araddr,
  output logic [7:0]  o_wire_axi_arlen,
  output logic [2:0]  o_wire_axi_arsize,
  output logic [1:0]  o_wire_axi_arburst,
  output logic        o_wire_axi_arvalid,
  input  logic        i_wire_axi_arready,
  input  logic [31:0] i_wire_axi_rdata,
  input  logic [1:0]  i_wire_axi_rresp,
  input  logic        i_wire_axi_rlast,
  input  logic        i_wire_axi_rvalid,
  output logic        o_wire_axi_rready
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CALC  = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERROR = 3'd5;

  logic [2:0]  state;
  logic [31:0] addr;
  logic [31:0] remaining;
  logic [31:0] beats_q;
  logic [31:0] beats;
  logic [31:0] page_room;
  logic        err_flag;
  logic        beat_fire;

  // Burst size: limited by words left, the burst cap and the room left in the 4 KB page.
  always_comb begin
    page_room = (32'd4096 - {20'd0, addr[11:0]}) >> 2;
    beats     = remaining;
    if (beats > 32'(PARAM_MAX_BURST)) beats = 32'(PARAM_MAX_BURST);
    if (beats > page_room)            beats = page_room;
  end

  // Once an error beat is seen the rest of the burst is drained regardless of the consumer.
  assign o_wire_axi_rready  = (state == ST_DATA) & (i_wire_data_next | err_flag);
  assign beat_fire          = o_wire_axi_rready & i_wire_axi_rvalid;
  assign o_wire_data_valid  = (state == ST_DATA) & i_wire_axi_rvalid & i_wire_data_next &
                              ~err_flag & ~i_wire_axi_rresp[1];
  assign o_wire_data        = i_wire_axi_rdata;
  assign o_wire_axi_arsize  = 3'b010;
  assign o_wire_axi_arburst = 2'b01;

  always_ff @(posedge i_wire_clock) begin
    if (!i_wire_resetn) begin
      state              <= ST_IDLE;
      o_wire_done        <= 1'b0;
      o_wire_error       <= 1'b0;
      o_wire_axi_arvalid <= 1'b0;
      o_wire_axi_araddr  <= 32'd0;
      o_wire_axi_arlen   <= 8'd0;
      err_flag           <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_wire_address[1:0] != 2'b00) begin
            state        <= ST_ERROR;
            o_wire_error <= 1'b1;
          end else if (i_wire_length == 32'd0) begin
            state       <= ST_DONE;
            o_wire_done <= 1'b1;
          end else begin
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          o_wire_axi_araddr  <= addr;
          o_wire_axi_arlen   <= 8'(beats - 32'd1);
          o_wire_axi_arvalid <= 1'b1;
          state              <= ST_ADDR;
        end
        ST_ADDR: begin
          if (i_wire_axi_arready) begin
            o_wire_axi_arvalid <= 1'b0;
            state              <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat_fire) begin
            if (i_wire_axi_rresp[1]) err_flag <= 1'b1;
            if (i_wire_axi_rlast) begin
              if (err_flag | i_wire_axi_rresp[1]) begin
                state        <= ST_ERROR;
                o_wire_error <= 1'b1;
              end else if (remaining == beats_q) begin
                state       <= ST_DONE;
                o_wire_done <= 1'b1;
              end else begin
                state <= ST_CALC;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Transfer bookkeeping; only meaningful once the IDLE edge has latched the request.
  always_ff @(posedge i_wire_clock) begin
    case (state)
      ST_IDLE: begin
        addr      <= i_wire_address;
        remaining <= i_wire_length;
      end
      ST_CALC: beats_q <= beats;
      ST_DATA: begin
        if (beat_fire && i_wire_axi_rlast) begin
          remaining <= remaining - beats_q;
          addr      <= addr + (beats_q << 2);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
// Randomized bench for painterengine_gpu_dma_reader: AXI slave model plus an
// expected-burst / expected-word scoreboard derived from the transfer request.
module tb_painterengine_gpu_dma_reader;

  localparam int MAXB = 64;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] address, length;
  logic        done, error;
  logic [31:0] data;
  logic        data_valid, data_next;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  always #5 clk = ~clk;

  painterengine_gpu_dma_reader #(.PARAM_MAX_BURST(MAXB)) dut (
    .i_wire_clock(clk), .i_wire_resetn(resetn),
    .i_wire_address(address), .i_wire_length(length),
    .o_wire_done(done), .o_wire_error(error),
    .o_wire_data(data), .o_wire_data_valid(data_valid), .i_wire_data_next(data_next),
    .o_wire_axi_araddr(araddr), .o_wire_axi_arlen(arlen), .o_wire_axi_arsize(arsize),
    .o_wire_axi_arburst(arburst), .o_wire_axi_arvalid(arvalid), .i_wire_axi_arready(arready),
    .i_wire_axi_rdata(rdata), .i_wire_axi_rresp(rresp), .i_wire_axi_rlast(rlast),
    .i_wire_axi_rvalid(rvalid), .o_wire_axi_rready(rready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  logic [31:0] exp_ar_addr[$];
  logic [7:0]  exp_ar_len[$];
  logic [31:0] exp_words[$];

  // Reference: split the request into page-safe bursts; drop words from the error beat on
  // and issue no burst that starts after it.
  task automatic build_model(input logic [31:0] a0, input int len, input int err_beat);
    longint a, r, b, room, idx;
    exp_ar_addr.delete(); exp_ar_len.delete(); exp_words.delete();
    if (a0 % 4 != 0) return;
    a = a0; r = len; idx = 0;
    while (r > 0) begin
      room = (4096 - (a % 4096)) / 4;
      b = r;
      if (b > MAXB) b = MAXB;
      if (b > room) b = room;
      if (err_beat >= 0 && idx > err_beat) break;
      exp_ar_addr.push_back(32'(a));
      exp_ar_len.push_back(8'(b - 1));
      for (longint k = 0; k < b; k++)
        if (err_beat < 0 || idx + k < err_beat) exp_words.push_back(mem_word(32'(a + 4 * k)));
      idx += b; a += 4 * b; r -= b;
    end
  endtask

  logic        sl_active, rv_real, took;
  logic [31:0] sl_addr;
  int          sl_len, sl_beat, g_beat;

  task automatic drive_reset(input logic [31:0] a, input logic [31:0] len);
    @(negedge clk);
    resetn = 1'b0; address = a; length = len;
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = 32'd0; arready = 1'b0; data_next = 1'b0;
    sl_active = 1'b0; rv_real = 1'b0; took = 1'b0;
    @(negedge clk);
    #1;
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_error", 32'(error), 32'd0);
    check_val("rst_arvalid", 32'(arvalid), 32'd0);
    check_val("rst_araddr", araddr, 32'd0);
    check_val("rst_arlen", 32'(arlen), 32'd0);
    check_val("rst_rready", 32'(rready), 32'd0);
    check_val("rst_dvalid", 32'(data_valid), 32'd0);
    resetn = 1'b1;
  endtask

  // mode 0: random slave/consumer, 1: everything always ready, 2: data_next toggles
  task automatic run(input logic [31:0] a, input int len, input int err_beat, input int mode,
                     input int abort_at);
    logic exp_err, end_seen, errm, prev_stall, finished;
    logic [31:0] prev_a;
    logic [7:0]  prev_l;
    int post;
    build_model(a, len, err_beat);
    exp_err  = (a[1:0] != 2'b00) || (err_beat >= 0 && err_beat < len);
    end_seen = (a[1:0] != 2'b00) || (len == 0);
    errm = 1'b0; prev_stall = 1'b0; finished = 1'b0; post = 0; g_beat = 0;
    prev_a = 32'd0; prev_l = 8'd0;
    drive_reset(a, 32'(len));
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (cyc == abort_at) return;
      address   = $urandom;
      length    = $urandom;
      data_next = (mode == 1) ? 1'b1 : (mode == 2) ? ((cyc % 2) == 0) : ($urandom_range(0, 3) != 0);
      arready   = (mode == 1) ? 1'b1 : ($urandom_range(0, 2) == 0);
      if (!sl_active) begin
        rv_real = 1'b0;
        rvalid  = (mode == 0) && ($urandom_range(0, 3) == 0);
        rlast   = rvalid; rresp = 2'b00; rdata = $urandom;
      end else if (took || !rv_real) begin
        rvalid = 1'b0; rv_real = 1'b0; rlast = 1'b0; rresp = 2'b00;
        if (mode == 1 || $urandom_range(0, 3) != 0) begin
          rvalid = 1'b1; rv_real = 1'b1;
          rdata  = mem_word(sl_addr + 32'(sl_beat) * 4);
          rlast  = (sl_beat == sl_len - 1);
          rresp  = (g_beat == err_beat) ? 2'b10 : 2'b00;
        end
      end
      took = 1'b0;
      #1;
      check_val("done", 32'(done), 32'(end_seen && !exp_err));
      check_val("error", 32'(error), 32'(end_seen && exp_err));
      check_val("dvalid_wo_next", 32'(data_valid & ~data_next), 32'd0);
      check_val("dvalid_wo_hs", 32'(data_valid & ~(rvalid & rready)), 32'd0);
      if (!sl_active) check_val("rready_idle", 32'(rready), 32'd0);
      else            check_val("rready", 32'(rready), 32'(data_next | errm));
      if (end_seen) check_val("arvalid_end", 32'(arvalid), 32'd0);
      if (prev_stall) begin
        check_val("ar_hold_valid", 32'(arvalid), 32'd1);
        check_val("ar_hold_addr", araddr, prev_a);
        check_val("ar_hold_len", 32'(arlen), 32'(prev_l));
      end
      if (arvalid && arready) begin
        check_val("ar_expected", 32'(exp_ar_addr.size() != 0 && !sl_active), 32'd1);
        if (exp_ar_addr.size() != 0) begin
          check_val("araddr", araddr, exp_ar_addr.pop_front());
          check_val("arlen", 32'(arlen), 32'(exp_ar_len.pop_front()));
          check_val("arsize", 32'(arsize), 32'd2);
          check_val("arburst", 32'(arburst), 32'd1);
        end
        sl_active = 1'b1; sl_addr = araddr; sl_len = int'(arlen) + 1; sl_beat = 0;
      end
      prev_stall = arvalid && !arready; prev_a = araddr; prev_l = arlen;
      if (rvalid && rready && sl_active && rv_real) begin
        took = 1'b1;
        if (data_valid) begin
          check_val("word_expected", 32'(exp_words.size() != 0), 32'd1);
          if (exp_words.size() != 0) check_val("data", data, exp_words.pop_front());
        end
        if (rresp[1]) errm = 1'b1;
        g_beat++; sl_beat++;
        if (rlast) begin
          sl_active = 1'b0;
          if (exp_ar_addr.size() == 0) end_seen = 1'b1;
        end
      end
      if (end_seen) post++;
      if (post == 4) begin finished = 1'b1; break; end
    end
    check_val("finished", 32'(finished), 32'd1);
    check_val("ar_left", 32'(exp_ar_addr.size()), 32'd0);
    check_val("words_left", 32'(exp_words.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    int rl, re;
    run(32'h0000_1000, 64, -1, 1, -1);
    run(32'h0000_1FF0, 10, -1, 0, -1);
    run(32'h0000_0000, 130, -1, 2, -1);
    run(32'h0000_0800, 8, 4, 0, -1);
    run(32'h0000_0800, 8, 7, 1, -1);
    run(32'h0000_2000, 0, -1, 1, -1);
    run(32'h0000_1002, 16, -1, 1, -1);
    run(32'h0000_0400, 100, -1, 1, 20);
    run(32'h0000_0FF8, 70, -1, 0, -1);
    for (int i = 0; i < 8; i++) begin
      ra = ($urandom_range(0, 1) == 0) ? ($urandom & 32'h0000_3FFC)
                                       : 32'h0000_3000 - 32'($urandom_range(1, 20)) * 4;
      rl = $urandom_range(1, 200);
      re = ($urandom_range(0, 2) == 0) ? $urandom_range(0, rl - 1) : -1;
      run(ra, rl, re, 0, -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
